// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the MC_CPU datapath (MIPS subset).
// It steps each instruction through fetch, decode, execute, memory and writeback states.
// It drives the datapath mux selects and enables from the current state.
// Memory accesses wait on the mem_ready handshake.
// It counts retired instructions and stops in HALT until reset.
module mc_control_fsm #(
  parameter int          CNT_W    = 32,
  parameter logic [5:0]  OP_RTYPE = 6'h00,
  parameter logic [5:0]  OP_LW    = 6'h23,
  parameter logic [5:0]  OP_SW    = 6'h2b,
  parameter logic [5:0]  OP_BEQ   = 6'h04,
  parameter logic [5:0]  OP_ADDI  = 6'h08,
  parameter logic [5:0]  OP_J     = 6'h02,
  parameter logic [5:0]  OP_HALT  = 6'h3f
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             pc_write_s;
  logic             branch_s;

  // State and retire counter registers; reset overrides any stall or partial instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next-state sequencing: memory states hold until mem_ready, and HALT is absorbing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           state_d = S_FETCH;
      end
      S_DECODE: begin
        if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)                state_d = S_EXEC;
        else if (opcode == OP_BEQ)                  state_d = S_BRANCH;
        else if (opcode == OP_ADDI)                 state_d = S_ADDIEX;
        else if (opcode == OP_J)                    state_d = S_JUMP;
        else if (opcode == OP_HALT)                 state_d = S_HALT;
        else                                        state_d = S_FETCH;
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        if (mem_ready) state_d = S_MEMWB;
        else           state_d = S_MEMRD;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready) state_d = S_FETCH;
        else           state_d = S_MEMWR;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // An instruction retires when control returns to FETCH from any other state.
  always_comb begin
    retired_d = retired_q;
    if ((state_q != S_FETCH) && (state_q != S_HALT) && (state_d == S_FETCH)) begin
      retired_d = retired_q + CNT_ONE;
    end else begin
      retired_d = retired_q;
    end
  end

  // Moore decode of the datapath controls; the fetch enables are also gated by mem_ready.
  always_comb begin
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    halted     = 1'b0;
    pc_write_s = 1'b0;
    branch_s   = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        ir_write   = mem_ready;
        pc_write_s = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch_s  = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write_s = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
    pc_en = pc_write_s | (branch_s & zero);
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm.
// The reference model describes each instruction as its list of state codes.
// It also holds a per-state table of expected control values and a retire counter.
module tb_mc_control_fsm;

  localparam int         CNT_W   = 32;
  localparam logic [5:0] OP_RT   = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3f;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
  logic             mem_to_reg, reg_write, alu_src_a, halted;
  logic [1:0]       alu_src_b, alu_op, pc_src;
  logic [3:0]       state;
  logic [CNT_W-1:0] retired;

  int        checks = 0;
  int        failures = 0;
  int        exp_retired = 0;
  int        seq_q[$];
  logic [5:0] rand_ops [0:7];

  mc_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .state(state), .halted(halted),
    .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected control word for a state, packed in the same order as obs_ctrl.
  function automatic logic [15:0] exp_ctrl(input int st, input logic mr, input logic z);
    logic       e_pcen, e_iord, e_mrd, e_mwr, e_irw, e_rdst, e_m2r, e_rw, e_asa, e_hlt;
    logic [1:0] e_asb, e_aop, e_psrc;
    {e_pcen, e_iord, e_mrd, e_mwr, e_irw, e_rdst, e_m2r, e_rw, e_asa, e_hlt} = 10'd0;
    e_asb = 2'b00; e_aop = 2'b00; e_psrc = 2'b00;
    case (st)
      0:  begin e_mrd = 1'b1; e_asb = 2'b01; e_irw = mr; e_pcen = mr; end
      1:  e_asb = 2'b11;
      2:  begin e_asa = 1'b1; e_asb = 2'b10; end
      3:  begin e_mrd = 1'b1; e_iord = 1'b1; end
      4:  begin e_rw = 1'b1; e_m2r = 1'b1; end
      5:  begin e_mwr = 1'b1; e_iord = 1'b1; end
      6:  begin e_asa = 1'b1; e_aop = 2'b10; end
      7:  begin e_rw = 1'b1; e_rdst = 1'b1; end
      8:  begin e_asa = 1'b1; e_aop = 2'b01; e_psrc = 2'b01; e_pcen = z; end
      9:  begin e_asa = 1'b1; e_asb = 2'b10; end
      10: e_rw = 1'b1;
      11: begin e_psrc = 2'b10; e_pcen = 1'b1; end
      12: e_hlt = 1'b1;
      default: e_hlt = 1'b0;
    endcase
    return {e_pcen, e_iord, e_mrd, e_mwr, e_irw, e_rdst, e_m2r, e_rw, e_asa,
            e_asb, e_aop, e_psrc, e_hlt};
  endfunction

  // State path taken by each instruction class.
  function automatic void fill_seq(input logic [5:0] op);
    seq_q = {0, 1};
    case (op)
      OP_RT:   seq_q = {0, 1, 6, 7};
      OP_LW:   seq_q = {0, 1, 2, 3, 4};
      OP_SW:   seq_q = {0, 1, 2, 5};
      OP_BEQ:  seq_q = {0, 1, 8};
      OP_ADDI: seq_q = {0, 1, 9, 10};
      OP_J:    seq_q = {0, 1, 11};
      OP_HALT: seq_q = {0, 1, 12};
      default: seq_q = {0, 1};
    endcase
  endfunction

  // Compare every observable output with the model for expected state st.
  task automatic check_now(input int st);
    logic [15:0] obs_ctrl;
    obs_ctrl = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_src, halted};
    chk("state", {28'd0, state}, st);
    chk($sformatf("ctrl_s%0d", st), {16'd0, obs_ctrl}, {16'd0, exp_ctrl(st, mem_ready, zero)});
    chk("retired", retired, exp_retired);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    zero = 1'b0;
    @(posedge clk); @(negedge clk);
    exp_retired = 0;
    #1 check_now(0);
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  // Run one instruction.
  // zmode 0 or 1 forces the zero input; 2 randomizes it.
  // rnd selects random handshake stalls instead of the fixed fstall/mstall counts.
  // abort asserts reset during the first store-write stall cycle.
  task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall,
                           input int zmode, input bit rnd, input bit abort);
    int  steps[$];
    fill_seq(op);
    steps = seq_q;
    opcode = op;
    foreach (steps[k]) begin
      int st;
      int stalls;
      int want;
      bit waits;
      st = steps[k];
      stalls = 0;
      waits = (st == 0) || (st == 3) || (st == 5);
      want = (st == 0) ? fstall : mstall;
      forever begin
        if (waits) begin
          if (rnd) mem_ready = (stalls < 6 && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
          else     mem_ready = (stalls < want) ? 1'b0 : 1'b1;
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
        zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
        #1 check_now(st);
        if (abort && st == 5 && !mem_ready) begin
          reset = 1'b1;
          @(posedge clk); @(negedge clk);
          exp_retired = 0;
          mem_ready = 1'b0;
          #1 check_now(0);
          reset = 1'b0;
          return;
        end
        @(posedge clk); @(negedge clk);
        if (waits && !mem_ready) stalls++;
        else break;
      end
    end
    if (op != OP_HALT) exp_retired++;
  endtask

  initial begin
    rand_ops = '{OP_RT, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, 6'h11, 6'h15};
    reset = 1'b1; opcode = OP_RT; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    do_reset();

    run_instr(OP_RT, 0, 0, 2, 1'b0, 1'b0);
    run_instr(OP_LW, 0, 3, 2, 1'b0, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1, 1'b0, 1'b0);
    run_instr(OP_BEQ, 0, 0, 0, 1'b0, 1'b0);
    run_instr(6'h11, 0, 0, 2, 1'b0, 1'b0);
    run_instr(OP_SW, 2, 2, 2, 1'b0, 1'b0);
    run_instr(OP_ADDI, 1, 0, 2, 1'b0, 1'b0);
    run_instr(OP_J, 0, 0, 2, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_instr(rand_ops[$urandom_range(0, 7)], 0, 0, 2, 1'b1, 1'b0);
    end

    run_instr(OP_SW, 0, 3, 2, 1'b0, 1'b1);
    run_instr(OP_RT, 0, 0, 2, 1'b0, 1'b0);
    run_instr(OP_LW, 1, 1, 2, 1'b0, 1'b0);

    run_instr(OP_HALT, 0, 0, 2, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      opcode = rand_ops[$urandom_range(0, 7)];
      #1 check_now(12);
      @(posedge clk); @(negedge clk);
    end

    do_reset();
    run_instr(OP_RT, 0, 0, 2, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #1 check_now(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
